ifu_line_fetcher: RTL

- Parametrised instruction-fetch refill engine between the IFU/icache and the AXI4 read channel.
- Serves three request types:
  - uncached single-word fetch;
  - cacheable line fill using per-word single transfers, for slaves without burst support;
  - cacheable line fill as one INCR burst.
- Returns the requested instruction word plus, for cacheable requests, the full assembled line for the icache to write.

---
 rtl/ifu_line_fetcher.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/ifu_line_fetcher.sv
// Instruction-fetch refill engine: uncached word, per-word line fill or burst line fill over AXI4 read.
// Optional critical-word-first / early restart under `define IFU_CRITICAL_WORD_FIRST_EN.
module ifu_line_fetcher #(
    parameter int LINE_WORDS = 4,
    parameter int ID_W       = 4,
    parameter int AXI_ID     = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [31:0]              req_addr,
    input  logic                     req_cacheable,
    input  logic                     req_burst,
    output logic                     resp_valid,
    output logic [31:0]              resp_inst,
    output logic                     resp_err,
    output logic                     line_valid,
    output logic [31:0]              line_addr,
    output logic [32*LINE_WORDS-1:0] line_data,
    output logic                     arvalid,
    input  logic                     arready,
    output logic [31:0]              araddr,
    output logic [7:0]               arlen,
    output logic [2:0]               arsize,
    output logic [1:0]               arburst,
    output logic [ID_W-1:0]          arid,
    input  logic                     rvalid,
    output logic                     rready,
    input  logic [31:0]              rdata,
    input  logic [1:0]               rresp,
    input  logic                     rlast
);

`ifdef IFU_CRITICAL_WORD_FIRST_EN
    localparam bit CWF = 1'b1;
`else
    localparam bit CWF = 1'b0;
`endif

    localparam bit              MULTI     = (LINE_WORDS > 1);
    localparam int              IDX_W     = MULTI ? $clog2(LINE_WORDS) : 1;
    localparam int              CNT_W     = $clog2(LINE_WORDS) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LINE_WORDS - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(LINE_WORDS);
    localparam logic [31:0]     LINE_MASK = ~(32'(LINE_WORDS * 4) - 32'd1);
    localparam logic [1:0]      BURST_FIXED = 2'b00;
    localparam logic [1:0]      BURST_INCR  = 2'b01;
    localparam logic [1:0]      BURST_WRAP  = 2'b10;

    typedef enum logic [2:0] {
        IDLE, S_AR, S_R, L_AR, L_R, B_AR, B_R, DONE
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [31:2]               r_addr;
    logic                      r_cacheable;
    logic [CNT_W-1:0]          r_cnt;
    logic                      r_err;
    logic [31:0]               r_inst;
    logic [32*LINE_WORDS-1:0]  r_line;

    logic [31:0]               w_base;
    logic [IDX_W-1:0]          w_start;
    logic [IDX_W-1:0]          w_idx;
    logic [31:0]               w_crit_word;
    logic                      w_unused_addr;

    assign w_unused_addr = &{1'b0, req_addr[1:0]};
    assign w_base        = {r_addr, 2'b00} & LINE_MASK;
    assign w_start       = MULTI ? r_addr[IDX_W+1:2] : '0;
    // With critical-word-first the beat counter is an offset from the requested word.
    assign w_idx         = !MULTI ? '0 :
                           CWF    ? IDX_W'(w_start + r_cnt[IDX_W-1:0]) : r_cnt[IDX_W-1:0];

    always_comb begin
        w_crit_word = '0;
        for (int i = 0; i < LINE_WORDS; i++) begin
            if (w_start == IDX_W'(i)) w_crit_word = r_line[32*i +: 32];
        end
    end

    assign req_ready = (r_state == IDLE) && !rst;
    assign arsize    = 3'b010;
    assign arid      = ID_W'(AXI_ID);
    assign line_addr = w_base;
    assign line_data = r_line;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        arvalid     = 1'b0;
        araddr      = '0;
        arlen       = '0;
        arburst     = BURST_FIXED;
        rready      = 1'b0;
        resp_valid  = 1'b0;
        resp_inst   = '0;
        resp_err    = 1'b0;
        line_valid  = 1'b0;
        case (r_state)
            IDLE: begin
                if (req_valid)
                    w_state_nxt = !req_cacheable ? S_AR : (req_burst ? B_AR : L_AR);
            end
            S_AR: begin
                arvalid = 1'b1;
                araddr  = {r_addr, 2'b00};
                if (arready) w_state_nxt = S_R;
            end
            S_R: begin
                rready = 1'b1;
                if (rvalid) w_state_nxt = DONE;
            end
            L_AR: begin
                arvalid = 1'b1;
                araddr  = w_base | {{(30-IDX_W){1'b0}}, w_idx, 2'b00};
                arburst = BURST_INCR;
                if (arready) w_state_nxt = L_R;
            end
            L_R: begin
                rready = 1'b1;
                if (rvalid) w_state_nxt = (r_cnt == CNT_LAST) ? DONE : L_AR;
                if (CWF && rvalid && r_cnt == '0) begin
                    resp_valid = 1'b1;
                    resp_inst  = rdata;
                    resp_err   = |rresp;
                end
            end
            B_AR: begin
                arvalid = 1'b1;
                araddr  = CWF ? {r_addr, 2'b00} : w_base;
                arlen   = 8'(LINE_WORDS - 1);
                arburst = (CWF && MULTI) ? BURST_WRAP : BURST_INCR;
                if (arready) w_state_nxt = B_R;
            end
            B_R: begin
                rready = 1'b1;
                if (rvalid && rlast) w_state_nxt = DONE;
                if (CWF && rvalid && r_cnt == '0) begin
                    resp_valid = 1'b1;
                    resp_inst  = rdata;
                    resp_err   = |rresp;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
                resp_valid  = !(CWF && r_cacheable);
                resp_inst   = r_cacheable ? w_crit_word : r_inst;
                resp_err    = r_err;
                line_valid  = r_cacheable && !r_err;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr      <= '0;
            r_cacheable <= 1'b0;
            r_cnt       <= '0;
            r_err       <= 1'b0;
            r_inst      <= '0;
            r_line      <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_addr      <= req_addr[31:2];
                        r_cacheable <= req_cacheable;
                    end
                end
                S_R: begin
                    if (rvalid) begin
                        r_inst <= rdata;
                        r_err  <= |rresp;
                    end
                end
                L_R: begin
                    if (rvalid) begin
                        for (int i = 0; i < LINE_WORDS; i++) begin
                            if (w_idx == IDX_W'(i)) r_line[32*i +: 32] <= rdata;
                        end
                        r_err <= r_err | (|rresp);
                        if (r_cnt != CNT_LAST) r_cnt <= r_cnt + 1'b1;
                    end
                end
                B_R: begin
                    if (rvalid) begin
                        // Surplus beats are discarded; a short burst is flagged on its rlast.
                        if (r_cnt < CNT_FULL) begin
                            for (int i = 0; i < LINE_WORDS; i++) begin
                                if (w_idx == IDX_W'(i)) r_line[32*i +: 32] <= rdata;
                            end
                            r_cnt <= r_cnt + 1'b1;
                        end
                        r_err <= r_err | (|rresp) | (r_cnt >= CNT_FULL) |
                                 (rlast && r_cnt != CNT_LAST);
                    end
                end
                DONE: begin
                    r_cnt <= '0;
                    r_err <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
